// File: rtl/mem_dump_reader_if.sv
// mem_dump_reader_if
// Bundles the dump request/status, the data RAM debug read port and the
// byte handshake toward the UART transmitter.
// master : the dump reader (drives RAM read requests and transmit bytes)
// slave  : the environment (RAM model, transmitter, halt logic)
interface mem_dump_reader_if #(
   parameter int len    = 32,
   parameter int ADDR_W = 11
);
   logic              start;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [len-1:0]    mem_data;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              busy;
   logic              done;

   modport master (
      input  start,
      input  mem_data,
      input  tx_ready,
      output mem_rd_en,
      output mem_addr,
      output tx_data,
      output tx_valid,
      output busy,
      output done
   );

   modport slave (
      output start,
      output mem_data,
      output tx_ready,
      input  mem_rd_en,
      input  mem_addr,
      input  tx_data,
      input  tx_valid,
      input  busy,
      input  done
   );
endinterface

// File: rtl/mem_dump_reader.sv
// mem_dump_reader
// Post-halt debug reader for the MIPS data memory. On start it walks the data
// RAM debug port from word 0 to N_WORDS-1 and sends every word MSB byte first
// over a valid/ready byte handshake to the UART transmitter.
// Optional feature: define MEM_DUMP_HEADER_EN to prefix the dump with a single
// 8'hA5 marker byte (extra HDR state between IDLE and READ).
//
// Byte handshake: tx_valid high means tx_data holds a byte for the transmitter.
// A byte moves on every rising edge where tx_valid and tx_ready are both 1.
// Once tx_valid rises it stays high with tx_data unchanged until that transfer.
module mem_dump_reader #(
   parameter int len     = 32,
   parameter int N_WORDS = 2048,
   parameter int ADDR_W  = $clog2(N_WORDS)
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_dump_reader_if.master    bus,
   output logic [2:0]           o_state
);

   localparam int BYTES  = len / 8;
   localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);
   localparam logic [7:0]        HDR_BYTE  = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_WAIT = 3'd2,
      S_SEND = 3'd3,
`ifdef MEM_DUMP_HEADER_EN
      S_HDR  = 3'd5,
`endif
      S_DONE = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_idx;
   logic [BCNT_W-1:0]   r_byte_cnt;
   logic [len-1:0]      r_shift;

   logic                w_mem_rd_en;
   logic                w_tx_valid;
   logic [7:0]          w_tx_data;
   logic                w_busy;
   logic                w_done;
   logic                w_xfer;
   logic                w_last_byte;
   logic                w_last_word;

   // A byte leaves the shift register only in SEND; the header byte is
   // handled purely by the FSM.
   assign w_xfer      = (r_state == S_SEND) && bus.tx_ready;
   assign w_last_byte = (r_byte_cnt == LAST_BYTE);
   assign w_last_word = (r_idx == LAST_WORD);

   // State register; reset abandons any dump in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Word index, byte counter and the word shift register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx      <= '0;
         r_byte_cnt <= '0;
         r_shift    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_idx      <= '0;
                  r_byte_cnt <= '0;
               end
            end
            S_WAIT: begin
               // Registered RAM: data for the READ cycle is valid now.
               r_shift    <= bus.mem_data;
               r_byte_cnt <= '0;
            end
            S_SEND: begin
               if (w_xfer) begin
                  r_shift    <= r_shift << 8;
                  r_byte_cnt <= r_byte_cnt + 1'b1;
                  // Index only advances when another word follows, so it
                  // never wraps and mem_addr keeps the last word afterwards.
                  if (w_last_byte && !w_last_word) begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state and output decode.
   always_comb begin
      w_next_state = r_state;
      w_mem_rd_en  = 1'b0;
      w_tx_valid   = 1'b0;
      w_tx_data    = 8'h00;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
`ifdef MEM_DUMP_HEADER_EN
               w_next_state = S_HDR;
`else
               w_next_state = S_READ;
`endif
            end
         end
`ifdef MEM_DUMP_HEADER_EN
         S_HDR: begin
            w_busy     = 1'b1;
            w_tx_valid = 1'b1;
            w_tx_data  = HDR_BYTE;
            if (bus.tx_ready) begin
               w_next_state = S_READ;
            end
         end
`endif
         S_READ: begin
            w_busy       = 1'b1;
            w_mem_rd_en  = 1'b1;
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            w_busy       = 1'b1;
            w_next_state = S_SEND;
         end
         S_SEND: begin
            w_busy     = 1'b1;
            w_tx_valid = 1'b1;
            w_tx_data  = r_shift[len-1 -: 8];
            if (w_xfer && w_last_byte) begin
               w_next_state = w_last_word ? S_DONE : S_READ;
            end
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   assign bus.mem_rd_en = w_mem_rd_en;
   assign bus.mem_addr  = r_idx;
   assign bus.tx_valid  = w_tx_valid;
   assign bus.tx_data   = w_tx_data;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign o_state       = r_state;

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader
// Directed bench for mem_dump_reader with a 4-word RAM model. Expected bytes
// and RAM addresses are queued when a dump is requested and popped by the
// monitor as the DUT produces them. Honours MEM_DUMP_HEADER_EN.
module tb_mem_dump_reader;

   localparam int LEN = 32;
   localparam int NW  = 4;
   localparam int AW  = 2;
`ifdef MEM_DUMP_HEADER_EN
   localparam int TOTAL = 17;
`else
   localparam int TOTAL = 16;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_dump_reader_if #(.len(LEN), .ADDR_W(AW)) bus ();
   logic [2:0] dbg_state;

   mem_dump_reader #(.len(LEN), .N_WORDS(NW), .ADDR_W(AW)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .o_state (dbg_state)
   );

   // Registered RAM model of the data memory debug port.
   logic [31:0] ram [0:NW-1];
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_data <= ram[bus.mem_addr];
   end

   // ---------------- scoreboard state ----------------
   logic [7:0]    exp_q[$];
   logic [AW-1:0] exp_addr_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_xfer_cyc = -10;
   int gap = 0;
   int done_cnt = 0;
   int dump_bytes = 0;
   int ready_mode = 0;
   bit prev_stall = 0;
   bit gap_armed = 0;
   bit prev_valid = 0;
   logic [7:0] prev_data = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_dump();
`ifdef MEM_DUMP_HEADER_EN
      exp_q.push_back(8'hA5);
`endif
      for (int w = 0; w < NW; w++) begin
         logic [31:0] word;
         word = ram[w];
         exp_addr_q.push_back(AW'(w));
         for (int b = 0; b < 4; b++) exp_q.push_back(word[31-8*b -: 8]);
      end
      dump_bytes = 0;
   endtask

   // Returns just after the edge that samples start (E0).
   task automatic do_start();
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Returns at the negedge where done is high, or after the budget.
   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (bus.done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("done_timeout", 32'(bus.done === 1'b1), 1);
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_rd_en"},    bus.mem_rd_en, 0);
      check({pfx, "_addr"},     32'(bus.mem_addr), 0);
      check({pfx, "_tx_data"},  bus.tx_data, 0);
      check({pfx, "_tx_valid"}, bus.tx_valid, 0);
      check({pfx, "_busy"},     bus.busy, 0);
      check({pfx, "_done"},     bus.done, 0);
   endtask

   task automatic finish_dump(input string pfx, input int base);
      repeat (3) @(negedge clk);
      check({pfx, "_done_once"}, 32'(done_cnt - base), 1);
      check({pfx, "_bytes"}, 32'(dump_bytes), TOTAL);
      check({pfx, "_addr_q_left"}, 32'(exp_addr_q.size()), 0);
   endtask

   // tx_ready driver: mode 0 tied high, mode 1 one cycle on / three off.
   initial begin
      int rcyc;
      rcyc = 0;
      bus.tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) bus.tx_ready = 1'b1;
         else bus.tx_ready = ((rcyc % 4) == 0);
         rcyc++;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         prev_stall = 0;
         gap_armed  = 0;
         gap        = 0;
         prev_valid = 0;
      end else begin
         if (bus.mem_rd_en) begin
            check("rd_pending", 32'(exp_addr_q.size() != 0), 1);
            if (exp_addr_q.size() != 0) check("rd_addr", 32'(bus.mem_addr), 32'(exp_addr_q.pop_front()));
         end
         if (prev_stall) begin
            check("stall_valid", bus.tx_valid, 1);
            check("stall_data", bus.tx_data, prev_data);
         end
         if (bus.tx_valid && !prev_valid && gap_armed) check("word_gap", gap, 2);
         if (bus.tx_valid) begin
            gap = 0;
            gap_armed = 1;
         end else if (bus.busy) begin
            gap++;
         end
         if (!bus.busy) begin
            gap_armed = 0;
            gap = 0;
         end
         if (bus.tx_valid && bus.tx_ready) begin
            check("byte_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("byte", bus.tx_data, exp_q.pop_front());
            dump_bytes++;
            last_xfer_cyc = cyc;
         end
         if (bus.done) begin
            done_cnt++;
            check("done_busy", bus.busy, 0);
            check("done_after_last", cyc, last_xfer_cyc + 1);
            check("done_q_empty", 32'(exp_q.size()), 0);
         end
         prev_stall = bus.tx_valid && !bus.tx_ready;
         prev_data  = bus.tx_data;
         prev_valid = bus.tx_valid;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      int k;
      ram[0] = 32'h11223344;
      ram[1] = 32'hA0B0C0D0;
      ram[2] = 32'h00000000;
      ram[3] = 32'hFFFFFFFF;
      reset = 1'b1;
      bus.start = 1'b0;
      #3;
      check_outputs_zero("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);

      // Basic dump with latency checks.
      ready_mode = 0;
      base = done_cnt;
      push_dump();
      do_start();
      @(negedge clk);
`ifdef MEM_DUMP_HEADER_EN
      check("lat_hdr_valid", bus.tx_valid, 1);
      check("lat_hdr_data", bus.tx_data, 8'hA5);
      check("lat_hdr_rd_en", bus.mem_rd_en, 0);
`else
      check("lat_rd_en_e0", bus.mem_rd_en, 1);
      check("lat_valid_e0", bus.tx_valid, 0);
      @(negedge clk);
      check("lat_rd_en_e1", bus.mem_rd_en, 0);
      check("lat_valid_e1", bus.tx_valid, 0);
      @(negedge clk);
      check("lat_valid_e2", bus.tx_valid, 1);
      check("lat_data_e2", bus.tx_data, 8'h11);
`endif
      wait_done(500);
      finish_dump("basic", base);

      // Backpressure.
      ready_mode = 1;
      base = done_cnt;
      push_dump();
      do_start();
      wait_done(1000);
      finish_dump("bp", base);

      // Start while busy, then start on the DONE->IDLE edge.
      ready_mode = 0;
      base = done_cnt;
      push_dump();
      do_start();
      repeat (8) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(500);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("done_edge_start_busy", bus.busy, 0);
         check("done_edge_start_rd", bus.mem_rd_en, 0);
      end
      check("restart_done_once", 32'(done_cnt - base), 1);
      check("restart_bytes", 32'(dump_bytes), TOTAL);

      // Reset after byte 6 is accepted.
      push_dump();
      do_start();
      k = 0;
      while (dump_bytes < 6 && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("reach_byte6", 32'(dump_bytes), 6);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_outputs_zero("midreset");
      exp_q.delete();
      exp_addr_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      base = done_cnt;
      push_dump();
      do_start();
      wait_done(500);
      finish_dump("after_reset", base);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Post-halt debug reader for the MIPS data memory. When the pipeline halts, it walks the data RAM debug read port from word 0 to `N_WORDS-1`. Each 32-bit word is serialized into bytes, MSB first, and handed to the UART transmitter over a valid/ready byte handshake. It is the read-out counterpart of the memory stage, which is the only writer of that RAM during execution.

## Interface
- `len`, 32, data word width; must be a multiple of 8.
- `N_WORDS`, 2048, number of words dumped; equals data RAM depth.
- `ADDR_W`, `$clog2(N_WORDS)`, word-index width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  dump request, sampled each edge; normally driven by the registered halt flag from the memory stage.
- `mem_rd_en`  out  1  read enable to the data RAM debug port.
- `mem_addr`  out  ADDR_W  word index to the data RAM debug port.
- `mem_data`  in  len  RAM read data; valid exactly one cycle after the `mem_rd_en` cycle (registered RAM).
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter accepts `tx_data` this cycle.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- States:
  - `IDLE`
  - `HDR` (only with the macro)
  - `READ`
  - `WAIT`
  - `SEND`
  - `DONE`
- `IDLE`: `start`=1 clears the word index and byte counter, then goes to `HDR` (macro) or `READ`. `start` is ignored in every other state.
- `READ`: `mem_rd_en`=1 and `mem_addr`=index for exactly one cycle, then `WAIT`.
- `WAIT`: `mem_rd_en`=0. At the end of the cycle, `mem_data` is captured into a `len`-bit shift register and the byte counter is set to 0. Next state is `SEND`.
- `SEND`:
  - `tx_valid`=1 and `tx_data`=shift register[len-1:len-8].
  - A byte transfers on any edge where `tx_valid`=1 and `tx_ready`=1. On transfer, the shift register shifts left by 8 and the byte counter increments.
  - After byte `len/8-1` transfers: if index==`N_WORDS-1`, go to `DONE`; otherwise increment the index and go to `READ`.
- `DONE`: `done`=1 for one cycle, then `IDLE`.
- While `tx_valid`=1 and `tx_ready`=0, `tx_data` holds stable and `tx_valid` must not drop.
- `busy`=1 in `HDR`, `READ`, `WAIT` and `SEND`; 0 in `IDLE` and `DONE`.
- `mem_addr` holds its last value outside `READ`; its value is meaningful only while `mem_rd_en`=1.
- Word index is `ADDR_W` bits wide and never wraps. `N_WORDS` is not required to be a power of 2; termination is decided by comparison with `N_WORDS-1`.
- Total bytes per dump: `N_WORDS*len/8`, plus the header when the macro is defined.

## Timing
- Reset (asynchronous, any time including mid-dump): state=`IDLE`, and every output resets to 0: `mem_rd_en`, `mem_addr`, `tx_data`, `tx_valid`, `busy`, `done`. The index, byte counter and shift register also reset to 0. An interrupted dump is abandoned, not resumed.
- Latency (no macro), with `start` sampled at edge E0:
  - `mem_rd_en` is high during the cycle after E0.
  - `tx_valid` first rises after E2, i.e. 3 edges after `start`.
- Word-to-word gap: after the last-byte transfer edge, `tx_valid` is low for 2 cycles (`READ` + `WAIT`), then `tx_valid` rises for the next word.
- `done` rises one edge after the final transfer edge, lasts one cycle, and `busy` is already 0 during it.
- A `start` pulse on the same edge as `DONE`→`IDLE` is ignored; `start` is sampled only while in `IDLE`.

## Configuration
- `MEM_DUMP_HEADER_EN` defined: after `start`, state `HDR` drives `tx_valid`=1, `tx_data`=8'hA5 until accepted, then goes to `READ`. First RAM read is delayed by the header handshake; dump length becomes `N_WORDS*len/8+1` bytes.
- Not defined: no `HDR` state; `IDLE`→`READ` directly; no header byte is ever emitted.

## Test plan
- Basic dump, `N_WORDS`=4, RAM={32'h11223344, 32'hA0B0C0D0, 0, 32'hFFFFFFFF}, `tx_ready` tied 1, pulse `start`:
  - Required bytes: 11 22 33 44 A0 B0 C0 D0 00 00 00 00 FF FF FF FF.
  - `done` pulses exactly once, one cycle after the last byte.
  - `mem_addr` sequence on `mem_rd_en` cycles: 0, 1, 2, 3.
- Backpressure, same RAM, `tx_ready` toggling 1 cycle on / 3 off: same 16 bytes; `tx_data` stable and `tx_valid` held during every stall.
- Latency check: `start` at edge E0 with `tx_ready`=1 gives `mem_rd_en` high after E0, first `tx_valid` after E2 (no macro). There is a 2-cycle `tx_valid` gap between words.
- Start while busy: a second `start` pulse mid-dump produces no restart, the byte count stays 16, and there is a single `done`.
- Reset mid-dump: assert `reset` after byte 6 is accepted.
  - All outputs go to 0 asynchronously (same cycle).
  - A new `start` then dumps from word 0: first byte is 11.
- With `MEM_DUMP_HEADER_EN`: first byte is A5, followed by the 16 bytes above; total 17 bytes.
